// File: rtl/window_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two column-addressed line buffers supply rows r-1 and r-2; strobes only on in-frame windows.
module window_3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic [DATA_W-1:0] win9,
    output logic              win_valid
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [ROW_W-1:0]  row_q, row_d, row_cur;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];
    logic              win_valid_q, win_valid_d;

    // Position of the pixel on the bus; sof forces it to the frame origin.
    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
        lb1_rd  = lb1[col_cur];
        lb2_rd  = lb2[col_cur];
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        if (pix_valid) begin
            if (col_cur == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_cur == ROW_W'(IMG_H - 1)) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb2_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;
            win_valid_d = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
        end
    end

    // Line buffers: read-before-write at the same column, never reset.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2[col_cur] <= lb1_rd;
            lb1[col_cur] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign win1      = win_q[0];
    assign win2      = win_q[1];
    assign win3      = win_q[2];
    assign win4      = win_q[3];
    assign win5      = win_q[4];
    assign win6      = win_q[5];
    assign win7      = win_q[6];
    assign win8      = win_q[7];
    assign win9      = win_q[8];
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 on a 4x4 image with pixel value 4r+c+1 (+ frame offset).
module tb_window_3x3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
    logic       win_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [71:0] first_w, last_w;

    window_3x3 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
        .win6(win6), .win7(win7), .win8(win8), .win9(win9), .win_valid(win_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] obs_win();
        return {win1, win2, win3, win4, win5, win6, win7, win8, win9};
    endfunction

    // Reference window whose bottom-right pixel is (r,c) in a frame offset by base.
    function automatic logic [71:0] exp_win(input int base, input int r, input int c);
        logic [71:0] w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w = {w[63:0], 8'(base + 4 * (r - 2 + dr) + (c - 2 + dc) + 1)};
        return w;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        pix_valid = v;
        sof       = s;
        pix_in    = d;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic send_frame(input string name, input int base, input int gaps,
                              input bit use_sof, input bit sof_idle,
                              output logic [71:0] fw, output logic [71:0] lw);
        int  strobes = 0;
        bit  expv;
        fw = '0;
        lw = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (sof_idle && r == 1 && c == 1) begin
                    drive(1'b0, 1'b1, 8'hee);
                    check($sformatf("%s idle_sof_valid", name), 72'(win_valid), 72'(0));
                end
                drive(1'b1, use_sof && r == 0 && c == 0, 8'(base + 4 * r + c + 1));
                expv = (r >= 2) && (c >= 2);
                check($sformatf("%s valid r%0d c%0d", name, r, c), 72'(win_valid), 72'(expv));
                if (expv) begin
                    check($sformatf("%s win r%0d c%0d", name, r, c), obs_win(), exp_win(base, r, c));
                    if (strobes == 0) fw = obs_win();
                    lw = obs_win();
                end
                if (win_valid) strobes++;
                for (int g = 0; g < gaps; g++) begin
                    drive(1'b0, 1'b0, 8'h00);
                    check($sformatf("%s gap_valid r%0d c%0d", name, r, c), 72'(win_valid), 72'(0));
                    if (expv)
                        check($sformatf("%s gap_hold r%0d c%0d", name, r, c), obs_win(), exp_win(base, r, c));
                end
            end
        end
        check($sformatf("%s strobe_count", name), 72'(strobes), 72'(4));
    endtask

    initial begin
        rst       = 1'b1;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_win", obs_win(), 72'(0));
        check("reset_valid", 72'(win_valid), 72'(0));
        rst = 1'b0;

        // Continuous frame, then gapped frame, then offset frame back-to-back.
        send_frame("contig", 0, 0, 1'b1, 1'b0, first_w, last_w);
        check("contig_first", first_w, 72'h01_02_03_05_06_07_09_0a_0b);
        check("contig_last", last_w, 72'h06_07_08_0a_0b_0c_0e_0f_10);
        send_frame("gapped", 0, 3, 1'b1, 1'b0, first_w, last_w);
        check("gapped_first", first_w, 72'h01_02_03_05_06_07_09_0a_0b);
        check("gapped_last", last_w, 72'h06_07_08_0a_0b_0c_0e_0f_10);
        send_frame("frame2", 100, 0, 1'b1, 1'b0, first_w, last_w);
        check("frame2_first", first_w, 72'h65_66_67_69_6a_6b_6d_6e_6f);

        // sof on pixel 7 restarts the frame; next strobe is 10 pixels later.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, i == 0, 8'(200 + i));
            check($sformatf("midsof pre %0d valid", i), 72'(win_valid), 72'(0));
        end
        for (int k = 0; k <= 10; k++) begin
            drive(1'b1, k == 0, 8'(4 * (k / 4) + (k % 4) + 1));
            check($sformatf("midsof post %0d valid", k), 72'(win_valid), 72'(k == 10));
        end
        check("midsof_win", obs_win(), exp_win(0, 2, 2));

        // Asynchronous reset during row 2, between clock edges.
        for (int k = 0; k <= 10; k++) begin
            drive(1'b1, k == 0, 8'(4 * (k / 4) + (k % 4) + 1));
        end
        check("prerst_valid", 72'(win_valid), 72'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_win", obs_win(), 72'(0));
        check("async_rst_valid", 72'(win_valid), 72'(0));
        #1 rst = 1'b0;
        send_frame("postrst", 50, 0, 1'b0, 1'b0, first_w, last_w);
        check("postrst_first", first_w, 72'h33_34_35_37_38_39_3b_3c_3d);

        // sof with pix_valid low mid-row must be ignored.
        send_frame("idlesof", 0, 0, 1'b1, 1'b1, first_w, last_w);
        check("idlesof_first", first_w, 72'h01_02_03_05_06_07_09_0a_0b);
        check("idlesof_last", last_w, 72'h06_07_08_0a_0b_0c_0e_0f_10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_3x3.md
WINDOW_3X3 -- requirements
Module: window_3x3

Interface
REQ-001 Parameter: DATA_W, default 8, pixel width in bits.
REQ-002 Parameter: IMG_W, default 640, active pixels per line; legal range 3..4096.
REQ-003 Parameter: IMG_H, default 480, lines per frame; legal range 3..4096.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-high.
REQ-006 Port: pix_in  input  DATA_W  raster-order pixel stream.
REQ-007 Port: pix_valid  input  1  pix_in is accepted on every rising clk edge with pix_valid=1; no backpressure.
REQ-008 Port: sof  input  1  start of frame; qualified by pix_valid; marks that pixel as row 0, column 0.
REQ-009 Port: win1..win9  output  DATA_W each  3x3 neighbourhood, row-major; win1..win3 = row r-2, win4..win6 = row r-1, win7..win9 = row r; within each row, columns c-2, c-1, c; win5 is the centre pixel.
REQ-010 Port: win_valid  output  1  one-cycle strobe: win1..win9 hold a complete in-frame window.

Function
REQ-011 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1) giving (r,c) of the pixel being accepted.
REQ-012 Counter advance: on acceptance, column increments; at IMG_W-1 it wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-013 An accepted pixel with sof=1 SHALL be treated as (0,0), overriding the counters; the next accepted pixel is (0,1).
REQ-014 sof with pix_valid=0 SHALL be ignored.
REQ-015 Two line buffers, each IMG_W x DATA_W: LB1 holds row r-1, LB2 holds row r-2, both addressed by column.
REQ-016 On acceptance at column c: read LB1[c] and LB2[c]; write LB2[c] <= old LB1[c]; write LB1[c] <= pix_in.
REQ-017 Window shift on acceptance: win1<=win2, win2<=win3, win3<=LB2[c]; win4<=win5, win5<=win6, win6<=LB1[c]; win7<=win8, win8<=win9, win9<=pix_in.
REQ-018 Latency: the window whose bottom-right pixel is accepted at edge t SHALL appear on win1..win9 after edge t and remain stable until the next acceptance.
REQ-019 win_valid SHALL be 1 after edge t iff a pixel was accepted at t with r>=2 and c>=2; otherwise 0.
REQ-020 No border padding: windows straddling a line or frame edge SHALL NOT assert win_valid; exactly (IMG_W-2)*(IMG_H-2) strobes per complete frame.
REQ-021 Cycles with pix_valid=0 SHALL leave counters, line buffers and win1..win9 unchanged and drive win_valid=0.
REQ-022 No arithmetic is performed on pixel data; values pass unmodified at DATA_W.
REQ-023 Line buffers SHALL be single-clock RAM-inferable (one read, one write per accepted pixel, same address).

Reset
REQ-024 While rst=1: column=0, row=0, win1..win9=0, win_valid=0, asynchronously.
REQ-025 Line buffer contents are not reset; stale data is masked by REQ-019 because rows 0–1 after reset never strobe.
REQ-026 Reset mid-frame SHALL abandon the frame; the first accepted pixel after rst deassertion is (0,0) regardless of sof.

Verification (IMG_W=4, IMG_H=4, DATA_W=8, pixel value = 4r+c+1)
REQ-027 Continuous frame, pix_valid=1 every cycle -> first win_valid after pixel 11 with win1..win9 = 1,2,3,5,6,7,9,10,11; exactly 4 strobes, last window 6,7,8,10,11,12,14,15,16.
REQ-028 Same frame with pix_valid=0 for 3 cycles after every pixel -> identical 4 windows in order; win_valid low and outputs held during gaps.
REQ-029 Two back-to-back frames, second frame values +100 -> second frame's first strobe gives 101,102,103,105,106,107,109,110,111; no strobe on rows 0–1 of frame 2.
REQ-030 sof asserted on pixel 7 of a frame -> that pixel becomes (0,0); next strobe only after 10 further accepted pixels (the new (2,2)).
REQ-031 rst pulsed asynchronously between edges during row 2 -> outputs 0 immediately; win_valid stays 0 until new (2,2); post-reset windows contain no pre-reset pixels.
REQ-032 sof=1 with pix_valid=0 mid-row -> no effect on counters; window sequence unchanged versus REQ-027.
